// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - radix-2 iterative RV64M multiply/divide sequencer
// Define MDU_FAST_MUL_EN for single-cycle MUL/MULW; DIV/REM remain iterative.
module mdu_seq #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      mdu_op,
    input  logic            is_unsigned,
    input  logic            isTuncate,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] a_q, a_d;        // multiplier, or dividend shifting out / quotient shifting in
    logic [XLEN-1:0] b_q, b_d;        // multiplicand or divisor magnitude
    logic [XLEN-1:0] acc_q, acc_d;    // product accumulator or partial remainder
    logic [XLEN-1:0] result_q, result_d;
    logic            out_valid_q;
    logic            mul_q, mul_d;
    logic            rem_q, rem_d;
    logic            word_q, word_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;

    function automatic logic [XLEN-1:0] sext_w(input logic [31:0] x);
        return {{(XLEN-32){x[31]}}, x};
    endfunction

    logic            accept, in_mul, in_rem, sign1, sign2, div_zero, ovf, go_done;
    logic [31:0]     lo1, lo2, mag1_w, mag2_w;
    logic [XLEN-1:0] mag1_f, mag2_f, dividend_adj, special_res;

    assign accept   = in_valid && !flush && (state_q == S_IDLE);
    assign in_mul   = (mdu_op == 2'b00) || (mdu_op == 2'b11);
    assign in_rem   = (mdu_op == 2'b10);
    assign lo1      = src1[31:0];
    assign lo2      = src2[31:0];
    assign sign1    = !is_unsigned && (isTuncate ? src1[31] : src1[XLEN-1]);
    assign sign2    = !is_unsigned && (isTuncate ? src2[31] : src2[XLEN-1]);
    assign mag1_w   = sign1 ? (~lo1 + 32'd1) : lo1;
    assign mag2_w   = sign2 ? (~lo2 + 32'd1) : lo2;
    assign mag1_f   = sign1 ? (~src1 + XLEN'(1)) : src1;
    assign mag2_f   = sign2 ? (~src2 + XLEN'(1)) : src2;
    assign div_zero = isTuncate ? (lo2 == 32'd0) : (src2 == '0);
    assign ovf      = !is_unsigned && (isTuncate
                      ? (lo1 == 32'h8000_0000 && lo2 == 32'hFFFF_FFFF)
                      : (src1 == {1'b1, {(XLEN-1){1'b0}}} && src2 == '1));
    assign dividend_adj = isTuncate ? sext_w(lo1) : src1;

`ifdef MDU_FAST_MUL_EN
    logic [XLEN-1:0] prod;
    assign prod    = src1 * src2;
    assign go_done = in_mul || div_zero || ovf;
    always_comb begin
        special_res = '0;
        if (in_mul)
            special_res = isTuncate ? sext_w(prod[31:0]) : prod;
        else if (div_zero)
            special_res = in_rem ? dividend_adj : '1;
        else
            special_res = in_rem ? '0 : dividend_adj;
    end
`else
    assign go_done = !in_mul && (div_zero || ovf);
    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = in_rem ? dividend_adj : '1;
        else
            special_res = in_rem ? '0 : dividend_adj;
    end
`endif

    // One radix-2 step of whichever engine is active.
    logic [XLEN:0]   shifted;
    logic            ge;
    logic [XLEN-1:0] it_a, it_b, it_acc, q_s, r_s, pre, fin;

    assign shifted = {acc_q, a_q[XLEN-1]};
    assign ge      = shifted >= {1'b0, b_q};

    always_comb begin
        it_a   = a_q;
        it_b   = b_q;
        it_acc = acc_q;
        if (mul_q) begin
            it_acc = a_q[0] ? (acc_q + b_q) : acc_q;
            it_b   = b_q << 1;
            it_a   = a_q >> 1;
        end else begin
            it_acc = ge ? (shifted[XLEN-1:0] - b_q) : shifted[XLEN-1:0];
            it_a   = {a_q[XLEN-2:0], ge};
        end
    end

    assign q_s = negq_q ? (~it_a + XLEN'(1)) : it_a;
    assign r_s = negr_q ? (~it_acc + XLEN'(1)) : it_acc;
    assign pre = mul_q ? it_acc : (rem_q ? r_s : q_s);
    assign fin = word_q ? sext_w(pre[31:0]) : pre;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        mul_d    = mul_q;
        rem_d    = rem_q;
        word_d   = word_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mul_d  = in_mul;
                    rem_d  = in_rem;
                    word_d = isTuncate;
                    negq_d = sign1 ^ sign2;
                    negr_d = sign1;
                    cnt_d  = isTuncate ? 6'd31 : 6'd63;
                    acc_d  = '0;
                    if (in_mul) begin
                        a_d = src2;
                        b_d = src1;
                    end else begin
                        a_d = isTuncate ? {mag1_w, {(XLEN-32){1'b0}}} : mag1_f;
                        b_d = isTuncate ? {{(XLEN-32){1'b0}}, mag2_w} : mag2_f;
                    end
                    if (go_done) begin
                        state_d  = S_DONE;
                        result_d = special_res;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                a_d   = it_a;
                b_d   = it_b;
                acc_d = it_acc;
                if (cnt_q == 6'd0) begin
                    state_d  = S_DONE;
                    result_d = fin;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            mul_q       <= 1'b0;
            rem_q       <= 1'b0;
            word_q      <= 1'b0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            out_valid_q <= (state_d == S_DONE);
            mul_q       <= mul_d;
            rem_q       <= rem_d;
            word_q      <= word_d;
            negq_q      <= negq_d;
            negr_q      <= negr_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - self-checking bench for mdu_seq against an arithmetic reference model
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  mdu_op;
    logic        is_unsigned;
    logic        isTuncate;
    logic [63:0] src1;
    logic [63:0] src2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        busy;

    int errors = 0;
    int checks = 0;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT64 = 1;
    localparam int MUL_LAT32 = 1;
`else
    localparam int MUL_LAT64 = 65;
    localparam int MUL_LAT32 = 33;
`endif
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    mdu_seq #(.XLEN(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mdu_op     (mdu_op),
        .is_unsigned(is_unsigned),
        .isTuncate  (isTuncate),
        .src1       (src1),
        .src2       (src2),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V M semantics via native arithmetic, plus the latency rule.
    task automatic ref_model(input logic [1:0] op, input logic uns, input logic word,
                             input logic [63:0] a, input logic [63:0] b,
                             output logic [63:0] res, output int lat);
        logic [63:0] ua, ub, r;
        longint      sa, sb;
        if (op == 2'b01 || op == 2'b10) begin
            if (word) begin
                ua = uns ? {32'h0, a[31:0]} : sext32(a[31:0]);
                ub = uns ? {32'h0, b[31:0]} : sext32(b[31:0]);
            end else begin
                ua = a;
                ub = b;
            end
            lat = word ? 33 : 65;
            if (ub == 64'd0) begin
                r   = (op == 2'b01) ? '1 : ua;
                lat = 1;
            end else if (!uns && ub == '1 && ua == (word ? sext32(32'h8000_0000) : MIN64)) begin
                r   = (op == 2'b01) ? ua : 64'd0;
                lat = 1;
            end else if (uns) begin
                r = (op == 2'b01) ? (ua / ub) : (ua % ub);
            end else begin
                sa = ua;
                sb = ub;
                r  = (op == 2'b01) ? 64'(sa / sb) : 64'(sa % sb);
            end
        end else begin
            r   = a * b;
            lat = word ? MUL_LAT32 : MUL_LAT64;
        end
        res = word ? sext32(r[31:0]) : r;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic uns, input logic word,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        check({tag, "_rdy"}, {63'd0, in_ready}, 64'd1);
        mdu_op      = op;
        is_unsigned = uns;
        isTuncate   = word;
        src1        = a;
        src2        = b;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src1     = ~a;
        src2     = ~b;
        mdu_op   = ~op;
        lat      = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_res"}, result, exp);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] ra, rb, exp;
        logic [1:0]  rop;
        logic        runs, rword;
        int          elat, cyc, bad;

        rst_n = 1'b0; in_valid = 1'b0; mdu_op = 2'b00; is_unsigned = 1'b0; isTuncate = 1'b0;
        src1 = '0; src2 = '0; flush = 1'b0; out_ready = 1'b1;
        #2;
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_result", result, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("divu_100_7", 2'b01, 1'b1, 1'b0, 64'd100, 64'd7, 64'd14, 65);
        run_op("remu_100_7", 2'b10, 1'b1, 1'b0, 64'd100, 64'd7, 64'd2, 65);
        run_op("div_m7_2", 2'b01, 1'b0, 1'b0, -64'sd7, 64'd2, -64'sd3, 65);
        run_op("rem_m7_2", 2'b10, 1'b0, 1'b0, -64'sd7, 64'd2, -64'sd1, 65);
        run_op("divw_ovf", 2'b01, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1);
        run_op("div_ovf64", 2'b01, 1'b0, 1'b0, MIN64, '1, MIN64, 1);
        run_op("rem_ovf64", 2'b10, 1'b0, 1'b0, MIN64, '1, 64'd0, 1);
        run_op("div_by0", 2'b01, 1'b0, 1'b0, 64'd5, 64'd0, '1, 1);
        run_op("remuw_by0", 2'b10, 1'b1, 1'b1, 64'h1_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 1);
        run_op("mulw_ovfl", 2'b00, 1'b0, 1'b1, 64'h10000, 64'h10000, 64'd0, MUL_LAT32);
        run_op("mul_m3_5", 2'b00, 1'b0, 1'b0, -64'sd3, 64'd5, -64'sd15, MUL_LAT64);
        run_op("mul_op3", 2'b11, 1'b1, 1'b0, 64'd123456789, 64'd1000, 64'd123456789000, MUL_LAT64);
        run_op("divuw_big", 2'b01, 1'b1, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 33);

        for (int i = 0; i < 40; i++) begin
            rop   = 2'($urandom_range(0, 3));
            runs  = 1'($urandom_range(0, 1));
            rword = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: ra = MIN64;
                1: ra = {$urandom, 32'h8000_0000};
                2: ra = 64'($urandom_range(0, 5000));
                default: ra = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 6))
                0: rb = 64'd0;
                1: rb = '1;
                2: rb = 64'($urandom_range(1, 300));
                3: rb = {32'h0, $urandom};
                default: rb = {$urandom, $urandom};
            endcase
            ref_model(rop, runs, rword, ra, rb, exp, elat);
            run_op($sformatf("rand%0d_op%0d_u%0d_w%0d", i, rop, runs, rword), rop, runs, rword, ra, rb, exp, elat);
        end

        // Consumer stalls in DONE: result and in_ready must hold.
        @(negedge clk);
        mdu_op = 2'b01; is_unsigned = 1'b1; isTuncate = 1'b0;
        src1 = 64'd100; src2 = 64'd7; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("hold_reached_done", {63'd0, out_valid}, 64'd1);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_result_%0d", k), result, 64'd14);
            check($sformatf("hold_in_ready_%0d", k), {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_out_valid", {63'd0, out_valid}, 64'd0);
        check("release_in_ready", {63'd0, in_ready}, 64'd1);
        check("release_result_held", result, 64'd14);

        // Flush at cycle 20 of CALC.
        @(negedge clk);
        mdu_op = 2'b01; is_unsigned = 1'b1; isTuncate = 1'b0;
        src1 = 64'd1000; src2 = 64'd3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        check("flush_pre_busy", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", {63'd0, busy}, 64'd0);
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        bad = 0;
        for (int k = 0; k < 70; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) bad++;
        end
        check("flush_no_out_valid", 64'(bad), 64'd0);
        check("flush_result_held", result, 64'd14);

        // flush and in_valid together: request is refused.
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_vs_valid_busy", {63'd0, busy}, 64'd0);
        run_op("after_flush", 2'b10, 1'b1, 1'b0, 64'd1000, 64'd3, 64'd1, 65);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        mdu_op = 2'b00; is_unsigned = 1'b0; isTuncate = 1'b0;
        src1 = 64'd9; src2 = 64'd9; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (1) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", {63'd0, in_ready}, 64'd1);
        check("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_result", result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_reset", 2'b01, 1'b0, 1'b1, 64'hFFFF_FFF6, 64'd3, -64'sd3, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
